// File: rtl/adder_share_sequencer.sv
// adder_share_sequencer
// Shares one 4-bit ripple adder between two requesters. Each operation is a
// 4*NIBBLES-bit add or subtract. The operands are fed through the adder one
// nibble per cycle, LSB first. The inter-nibble carry is held in a register.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   reqN_valid/ready               request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sub       operands and op (0 = a+b, 1 = a-b)
//   rsp_valid                      one-cycle result pulse
//   rsp_id, rsp_sum                owning requester, result
//   rsp_carry, rsp_ovf             final carry out, two's-complement overflow
//   busy                           high while an operation is in flight

// Single-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// 4-bit ripple-carry adder built from four full adders.
module ripple_adder_4bit_structural (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[4];
endmodule

module adder_share_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_sub,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_carry,
  output logic                 rsp_ovf,
  output logic                 busy
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic         last_q;     // last-served requester
  logic         id_q;
  logic [W-1:0] a_q;
  logic [W-1:0] beff_q;     // b, pre-inverted for subtract
  logic [W-1:0] result_q;
  logic         carry_q;

  logic         grant0, grant1, accept;
  logic [W-1:0] sel_a, sel_b;
  logic         sel_sub;

  logic [IDX_W+1:0] lsb;
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic [W-1:0]     result_next;
  logic             last_nibble;

  // Round-robin: on a tie, the requester not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
  assign accept = req0_ready | req1_ready;

  assign sel_a   = req1_ready ? req1_a   : req0_a;
  assign sel_b   = req1_ready ? req1_b   : req0_b;
  assign sel_sub = req1_ready ? req1_sub : req0_sub;

  // Current nibble slice into the shared adder.
  assign lsb   = {idx_q, 2'b00};
  assign nib_a = a_q[lsb +: 4];
  assign nib_b = beff_q[lsb +: 4];

  ripple_adder_4bit_structural u_adder (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_q),
    .sum (nib_sum),
    .cout(nib_cout)
  );

  // Result with the current nibble merged in; used to load the response
  // on the final ADD edge.
  always_comb begin
    result_next           = result_q;
    result_next[lsb +: 4] = nib_sum;
  end

  assign last_nibble = (state_q == ADD) && (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and ready decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          state_d = ADD;
          idx_d   = '0;
        end
      end
      ADD: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Operand capture and nibble-serial accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      a_q      <= '0;
      beff_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      last_q   <= req1_ready;
      id_q     <= req1_ready;
      a_q      <= sel_a;
      beff_q   <= sel_b ^ {W{sel_sub}};
      carry_q  <= sel_sub;
    end else if (state_q == ADD) begin
      result_q <= result_next;
      carry_q  <= nib_cout;
    end
  end

  // Response fields load on the last ADD edge and hold until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (last_nibble) begin
      rsp_id    <= id_q;
      rsp_sum   <= result_next;
      rsp_carry <= nib_cout;
      rsp_ovf   <= (a_q[W-1] == beff_q[W-1]) && (result_next[W-1] != a_q[W-1]);
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Directed bench for adder_share_sequencer (NIBBLES = 4).
module tb_adder_share_sequencer;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf, busy;
  logic [W-1:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_share_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    end
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_ready0"}, 32'(req0_ready), 32'(r0));
    chk({tag, "_ready1"}, 32'(req1_ready), 32'(r1));
  endtask

  // Called at the negedge of the accepting IDLE cycle. Walks ADD x4 and DONE,
  // then returns at the negedge of the following IDLE cycle.
  // drop: release both valids (and scramble operands) right after accept.
  // late_at: raise req1 valid at this step (0 = never).
  task automatic run_op(input string tag, input bit drop, input int late_at,
                        input logic exp_id, input logic [W-1:0] exp_sum,
                        input logic exp_c, input logic exp_o);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1 && drop) begin
        set_req(0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
        set_req(1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
      end
      if (i == late_at) set_req(1, 1'b1, 16'h0020, 16'h0010, 1'b1);
      #1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready0_blk"}, 32'(req0_ready), 32'd0);
      chk({tag, "_ready1_blk"}, 32'(req1_ready), 32'd0);
      if (i < 5) begin
        chk({tag, "_rsp_valid_low"}, 32'(rsp_valid), 32'd0);
      end else begin
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_rsp_sum"}, 32'(rsp_sum), 32'(exp_sum));
        chk({tag, "_rsp_carry"}, 32'(rsp_carry), 32'(exp_c));
        chk({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'(exp_o));
      end
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_sum_hold"}, 32'(rsp_sum), 32'(exp_sum));
  endtask

  initial begin
    reset_n = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_ready("rst", 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_ready("idle", 1'b0, 1'b0);

    // Basic add
    set_req(0, 1'b1, 16'h1234, 16'h0FFF, 1'b0);
    chk_ready("basic", 1'b1, 1'b0);
    run_op("basic", 1'b1, 0, 1'b0, 16'h2233, 1'b0, 1'b0);

    // Carry out
    set_req(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    chk_ready("carry", 1'b1, 1'b0);
    run_op("carry", 1'b1, 0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Positive overflow, via requester 1
    set_req(1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    chk_ready("ovf", 1'b0, 1'b1);
    run_op("ovf", 1'b1, 0, 1'b1, 16'h8000, 1'b0, 1'b1);

    // Subtract with borrow
    set_req(0, 1'b1, 16'h0005, 16'h0007, 1'b1);
    chk_ready("sub_borrow", 1'b1, 1'b0);
    run_op("sub_borrow", 1'b1, 0, 1'b0, 16'hFFFE, 1'b0, 1'b0);

    // Subtract overflow, via requester 1 (leaves last-served = 1)
    set_req(1, 1'b1, 16'h8000, 16'h0001, 1'b1);
    chk_ready("sub_ovf", 1'b0, 1'b1);
    run_op("sub_ovf", 1'b1, 0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Contention: both valid held, grants alternate 0,1,0,1 every 6 cycles
    set_req(0, 1'b1, 16'h0100, 16'h0023, 1'b0);
    set_req(1, 1'b1, 16'h1000, 16'h0001, 1'b1);
    chk_ready("cont0", 1'b1, 1'b0);
    run_op("cont0", 1'b0, 0, 1'b0, 16'h0123, 1'b0, 1'b0);
    chk_ready("cont1", 1'b0, 1'b1);
    run_op("cont1", 1'b0, 0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    chk_ready("cont2", 1'b1, 1'b0);
    run_op("cont2", 1'b0, 0, 1'b0, 16'h0123, 1'b0, 1'b0);
    chk_ready("cont3", 1'b0, 1'b1);
    run_op("cont3", 1'b1, 0, 1'b1, 16'h0FFF, 1'b1, 1'b0);

    // Late request: req1 raised during req0's ADD
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    chk_ready("late0", 1'b1, 1'b0);
    run_op("late0", 1'b1, 2, 1'b0, 16'h0007, 1'b0, 1'b0);
    chk_ready("late1", 1'b0, 1'b1);
    run_op("late1", 1'b1, 0, 1'b1, 16'h0010, 1'b1, 1'b0);

    // Reset mid-operation (req0 accept sets last-served = 0 first)
    set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    chk_ready("mid", 1'b1, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("mid_rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
    chk_ready("mid_rst", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end

    // Both valid after reset: pointer reset to 1, so req0 wins
    set_req(0, 1'b1, 16'h4000, 16'h4000, 1'b0);
    set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
    chk_ready("post_rst", 1'b1, 1'b0);
    run_op("post_rst", 1'b1, 0, 1'b0, 16'h8000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
